// File: rtl/dac_mux_scanner.sv
// dac_mux_scanner
//   Refreshes CH_NUM sample-and-hold outputs from one SPI DAC through an
//   analog multiplexer. For each channel it loads a frame, shifts it out,
//   waits for the DAC to settle, then connects the mux for HOLD_CYC cycles.
//   It then advances to the next channel. Per-channel codes are held in a
//   register file that can be written at any time.
//
// Ports
//   clk, rst_n        : clock, asynchronous active-low reset
//   en                : scan enable (the current channel always completes)
//   pd                : DAC power-down field placed in every frame
//   wr_en/addr/data   : register-file write port (out-of-range addresses ignored)
//   sclk, dout, sync_n: SPI to the DAC (sclk idles high, MSB first)
//   pos, inh          : mux select and inhibit (inh=1 opens all switches)
//   busy              : FSM not idle
//   cur_ch            : channel being serviced
//   round_done        : one-cycle pulse after the last channel's hold window
module dac_mux_scanner #(
  parameter int unsigned CH_NUM     = 8,
  parameter int unsigned POS_W      = 3,
  parameter int unsigned DATA_W     = 12,
  parameter int unsigned FRAME_W    = 16,
  parameter int unsigned CLK_DIV    = 2,
  parameter int unsigned DAC_SETTLE = 16,
  parameter int unsigned HOLD_CYC   = 32,
  parameter int unsigned RST_CODE   = 2048
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [1:0]        pd,
  input  logic              wr_en,
  input  logic [7:0]        wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              sclk,
  output logic              dout,
  output logic              sync_n,
  output logic [POS_W-1:0]  pos,
  output logic              inh,
  output logic              busy,
  output logic [POS_W-1:0]  cur_ch,
  output logic              round_done
);

  localparam int unsigned CNT_MAX =
    (CLK_DIV > DAC_SETTLE) ? ((CLK_DIV > HOLD_CYC) ? CLK_DIV : HOLD_CYC)
                           : ((DAC_SETTLE > HOLD_CYC) ? DAC_SETTLE : HOLD_CYC);
  localparam int unsigned CNT_W = $clog2(CNT_MAX + 1);
  localparam int unsigned BIT_W = $clog2(FRAME_W + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_SETTLE,
    S_HOLD
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic [FRAME_W-1:0] sh_q, sh_d;
  logic               sclk_q, sclk_d;
  logic               sync_n_q, sync_n_d;
  logic [POS_W-1:0]   pos_q, pos_d;
  logic               inh_q, inh_d;
  logic [POS_W-1:0]   cur_ch_q, cur_ch_d;
  logic               done_q, done_d;

  logic [DATA_W-1:0]  regs_q [CH_NUM];
  logic [DATA_W-1:0]  sel_code;
  logic [FRAME_W-1:0] frame;

  // Register file: writable in every state; the LOAD snapshot reads the
  // pre-edge value, so a write on the LOAD edge lands in the next round.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < CH_NUM; i++) begin
        regs_q[i] <= DATA_W'(RST_CODE);
      end
    end else if (wr_en) begin
      for (int unsigned i = 0; i < CH_NUM; i++) begin
        if (32'(wr_addr) == i) begin
          regs_q[i] <= wr_data;
        end
      end
    end
  end

  always_comb begin
    sel_code = '0;
    for (int unsigned i = 0; i < CH_NUM; i++) begin
      if (32'(cur_ch_q) == i) begin
        sel_code = regs_q[i];
      end
    end
  end

  always_comb begin
    frame                     = '0;
    frame[DATA_W+1:DATA_W]    = pd;
    frame[DATA_W-1:0]         = sel_code;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      sh_q     <= '0;
      sclk_q   <= 1'b1;
      sync_n_q <= 1'b1;
      pos_q    <= '0;
      inh_q    <= 1'b1;
      cur_ch_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      sh_q     <= sh_d;
      sclk_q   <= sclk_d;
      sync_n_q <= sync_n_d;
      pos_q    <= pos_d;
      inh_q    <= inh_d;
      cur_ch_q <= cur_ch_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    sh_d     = sh_q;
    sclk_d   = sclk_q;
    sync_n_d = sync_n_q;
    pos_d    = pos_q;
    inh_d    = inh_q;
    cur_ch_d = cur_ch_q;
    done_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (en) begin
          state_d = S_LOAD;
        end
      end

      S_LOAD: begin
        sh_d     = frame;
        sync_n_d = 1'b0;
        sclk_d   = 1'b1;
        cnt_d    = '0;
        bit_d    = '0;
        state_d  = S_SHIFT;
      end

      // cnt_q times each sclk phase. dout is the shift register MSB, so it
      // advances only on the low->high sclk transition. The rising edge after
      // the last bit's low phase ends the frame instead.
      S_SHIFT: begin
        if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
          cnt_d = '0;
          if (sclk_q) begin
            sclk_d = 1'b0;
          end else if (bit_q == BIT_W'(FRAME_W - 1)) begin
            sclk_d   = 1'b1;
            sync_n_d = 1'b1;
            sh_d     = '0;
            state_d  = S_SETTLE;
          end else begin
            sclk_d = 1'b1;
            sh_d   = sh_q << 1;
            bit_d  = bit_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_SETTLE: begin
        if (cnt_q == CNT_W'(DAC_SETTLE - 1)) begin
          cnt_d   = '0;
          pos_d   = cur_ch_q;
          inh_d   = 1'b0;
          state_d = S_HOLD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_HOLD: begin
        if (cnt_q == CNT_W'(HOLD_CYC - 1)) begin
          cnt_d = '0;
          inh_d = 1'b1;
          if (32'(cur_ch_q) == CH_NUM - 1) begin
            cur_ch_d = '0;
            done_d   = 1'b1;
          end else begin
            cur_ch_d = cur_ch_q + 1'b1;
          end
          state_d = en ? S_LOAD : S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign sclk       = sclk_q;
  assign dout       = sh_q[FRAME_W-1];
  assign sync_n     = sync_n_q;
  assign pos        = pos_q;
  assign inh        = inh_q;
  assign busy       = (state_q != S_IDLE);
  assign cur_ch     = cur_ch_q;
  assign round_done = done_q;

endmodule

// File: tb/tb_dac_mux_scanner.sv
// Testbench for dac_mux_scanner at default parameters. The reference model
// treats each frame as a value: {pd, code of the channel} sampled at the
// snapshot edge. It also uses the timing counts of a channel (64 sync_n-low
// cycles, 16 settle cycles, 32 hold cycles) and the channel sequence 0..7.
module tb_dac_mux_scanner;
  localparam int unsigned CH = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [1:0]  pd = 2'b00;
  logic        wr_en = 1'b0;
  logic [7:0]  wr_addr = 8'd0;
  logic [11:0] wr_data = 12'd0;
  logic        sclk, dout, sync_n, inh, busy, round_done;
  logic [2:0]  pos, cur_ch;

  always #5 clk = ~clk;

  dac_mux_scanner #(
    .CH_NUM(8), .POS_W(3), .DATA_W(12), .FRAME_W(16), .CLK_DIV(2),
    .DAC_SETTLE(16), .HOLD_CYC(32), .RST_CODE(2048)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .pd(pd),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .sclk(sclk), .dout(dout), .sync_n(sync_n), .pos(pos), .inh(inh),
    .busy(busy), .cur_ch(cur_ch), .round_done(round_done)
  );

  int compared = 0;
  int mismatched = 0;
  int viol = 0;
  int cyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference register file: mdl_old holds the values before the most recent
  // clock edge, which is what a snapshot taken on that edge must see.
  logic [11:0] mdl [CH];
  logic [11:0] mdl_old [CH];
  logic [1:0]  pd_edge;
  always @(posedge clk) begin
    cyc++;
    mdl_old = mdl;
    pd_edge = pd;
    if (!rst_n) begin
      for (int i = 0; i < CH; i++) begin
        mdl[i] = 12'd2048;
        mdl_old[i] = 12'd2048;
      end
    end else if (wr_en && wr_addr < CH) begin
      mdl[wr_addr[2:0]] = wr_data;
    end
  end

  // Monitor: reconstructs frames from falling sclk edges and checks each one
  // against the model, together with the settle/hold timing and invariants.
  logic        p_sync = 1'b1, p_sclk = 1'b1, p_inh = 1'b1, p_dout = 1'b0;
  logic [2:0]  p_pos = 3'd0;
  logic        in_frame = 1'b0, in_settle = 1'b0, in_hold = 1'b0;
  logic [15:0] cap, exp_frame, last_frame;
  int nb, low, gap, hold, last_ch, last_nb, last_low;
  int exp_ch = 0;
  int frames = 0;
  int holds_done = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      p_sync = 1'b1; p_sclk = 1'b1; p_inh = 1'b1; p_dout = 1'b0; p_pos = 3'd0;
      in_frame = 1'b0; in_settle = 1'b0; in_hold = 1'b0; exp_ch = 0;
    end else begin
      if (!inh && !sync_n) viol++;
      if (pos !== p_pos && !p_inh) viol++;
      if (sync_n && !sclk) viol++;
      if (!sync_n && !p_sync && dout !== p_dout && !(sclk && !p_sclk)) viol++;
      if (round_done && !(inh && !p_inh && in_hold)) viol++;

      if (p_sync && !sync_n) begin
        in_frame = 1'b1; cap = '0; nb = 0; low = 0;
        exp_frame = {2'b00, pd_edge, mdl_old[cur_ch]};
        chk("frame_channel", 32'(cur_ch), 32'(exp_ch));
      end

      if (in_frame) begin
        if (!sync_n) begin
          low++;
          if (p_sclk && !sclk) begin
            cap = {cap[14:0], dout};
            nb++;
          end
        end else begin
          in_frame = 1'b0;
          chk("frame_bits", 32'(cap), 32'(exp_frame));
          chk("frame_nbits", nb, 16);
          chk("sync_low_len", low, 64);
          last_frame = cap; last_ch = int'(cur_ch); last_nb = nb; last_low = low;
          frames++;
          in_settle = 1'b1; gap = 1;
        end
      end else if (in_settle) begin
        if (inh) begin
          gap++;
        end else begin
          chk("settle_len", gap, 16);
          chk("hold_pos", 32'(pos), 32'(exp_ch));
          in_settle = 1'b0; in_hold = 1'b1; hold = 1;
        end
      end else if (in_hold) begin
        if (!inh) begin
          hold++;
        end else begin
          chk("hold_len", hold, 32);
          chk("round_done_at_wrap", 32'(round_done), 32'(exp_ch == CH - 1));
          exp_ch = (exp_ch + 1) % CH;
          in_hold = 1'b0;
          holds_done++;
        end
      end

      p_sync = sync_n; p_sclk = sclk; p_inh = inh; p_dout = dout; p_pos = pos;
    end
  end

  // Main sequence samples at negedge+1 so monitor updates are already visible.
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_frames(input int n);
    int target;
    logic ok;
    target = frames + n;
    ok = 1'b0;
    for (int i = 0; i < 150 * n + 200; i++) begin
      if (frames >= target) begin ok = 1'b1; break; end
      step();
    end
    chk("wait_frames_timeout", 32'(ok), 32'd1);
  endtask

  task automatic wait_holds(input int n);
    int target;
    logic ok;
    target = holds_done + n;
    ok = 1'b0;
    for (int i = 0; i < 150 * n + 200; i++) begin
      if (holds_done >= target) begin ok = 1'b1; break; end
      step();
    end
    chk("wait_holds_timeout", 32'(ok), 32'd1);
  endtask

  task automatic wait_shift_on(input int ch);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (!sync_n && int'(cur_ch) == ch) begin ok = 1'b1; break; end
      step();
    end
    chk("wait_shift_timeout", 32'(ok), 32'd1);
  endtask

  task automatic wait_round_done(output int t);
    logic ok;
    ok = 1'b0;
    t = 0;
    for (int i = 0; i < 1200; i++) begin
      step();
      if (round_done) begin ok = 1'b1; t = cyc; break; end
    end
    chk("wait_round_done_timeout", 32'(ok), 32'd1);
  endtask

  task automatic do_write(input logic [7:0] a, input logic [11:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_sclk"}, 32'(sclk), 32'd1);
    chk({tag, "_dout"}, 32'(dout), 32'd0);
    chk({tag, "_sync_n"}, 32'(sync_n), 32'd1);
    chk({tag, "_pos"}, 32'(pos), 32'd0);
    chk({tag, "_inh"}, 32'(inh), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_cur_ch"}, 32'(cur_ch), 32'd0);
    chk({tag, "_round_done"}, 32'(round_done), 32'd0);
  endtask

  initial begin
    int t1, t2, c, c2, f0;
    logic [11:0] old_v, new_v, oth_v;

    // Reset state
    repeat (3) step();
    chk_reset_outputs("reset");

    // First frame after release: ch0 at reset code, pd=0
    rst_n = 1'b1; en = 1'b1; pd = 2'b00;
    wait_frames(1);
    chk("first_frame", 32'(last_frame), 32'h0800);
    chk("first_frame_ch", last_ch, 0);
    chk("first_sync_low", last_low, 64);

    // Write ch0=900 with pd=01; seen on ch0's next frame
    do_write(8'd0, 12'd900);
    pd = 2'b01;
    wait_frames(8);
    chk("write_frame", 32'(last_frame), 32'h1384);
    chk("write_frame_ch", last_ch, 0);

    // Full round period with en held high
    wait_round_done(t1);
    wait_round_done(t2);
    chk("round_period", t2 - t1, 904);

    // Random writes (including out-of-range addresses) and pd changes
    for (int k = 0; k < 12; k++) begin
      repeat ($urandom_range(20, 300)) step();
      do_write(8'($urandom_range(0, 9)), 12'($urandom));
      if ($urandom_range(0, 3) == 0) pd = 2'($urandom);
    end
    do_write(8'd8, 12'hFFF);
    do_write(8'd200, 12'h123);
    wait_frames(9);

    // Write to the channel being loaded, on the LOAD edge
    wait_holds(1);
    c = int'(cur_ch);
    old_v = mdl[c];
    new_v = old_v ^ 12'hA5A;
    do_write(8'(c), new_v);
    wait_frames(1);
    chk("load_race_old", 32'(last_frame[11:0]), 32'(old_v));
    chk("load_race_old_ch", last_ch, c);
    wait_frames(8);
    chk("load_race_new", 32'(last_frame[11:0]), 32'(new_v));

    // Write during SHIFT to another channel
    wait_shift_on((c + 1) % CH);
    c2 = (c + 3) % CH;
    oth_v = 12'($urandom);
    do_write(8'(c2), oth_v);
    wait_frames(3);
    chk("shift_write_ch", last_ch, c2);
    chk("shift_write_val", 32'(last_frame[11:0]), 32'(oth_v));

    // en dropped mid-SHIFT on ch3
    wait_shift_on(3);
    repeat (10) step();
    en = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (!busy) break;
      step();
    end
    chk("endrop_busy", 32'(busy), 32'd0);
    chk("endrop_last_ch", last_ch, 3);
    chk("endrop_last_nbits", last_nb, 16);
    chk("endrop_cur_ch", 32'(cur_ch), 32'd4);
    chk("endrop_inh", 32'(inh), 32'd1);
    f0 = frames;
    repeat (40) step();
    chk("endrop_idle_busy", 32'(busy), 32'd0);
    chk("endrop_no_frame", frames, f0);
    en = 1'b1;
    wait_frames(1);
    chk("resume_ch", last_ch, 4);

    // Asynchronous reset mid-SHIFT
    wait_shift_on(6);
    repeat (5) step();
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("async_reset");
    en = 1'b0; pd = 2'b00;
    repeat (3) step();
    chk_reset_outputs("reset_hold");
    rst_n = 1'b1; en = 1'b1;
    wait_frames(1);
    chk("post_reset_frame", 32'(last_frame), 32'h0800);
    chk("post_reset_ch", last_ch, 0);
    wait_frames(8);
    chk("post_reset_ch0_again", 32'(last_frame), 32'h0800);

    chk("invariants", viol, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
